// File: rtl/alu_arith_pipe.sv
// Two-stage pipelined adder ALU with accumulator; optional {C,V,N,Z} flags when ALU_ARITH_PIPE_FLAGS_EN is defined.
// Latency: 2 clock edges from input acceptance to Out_valid; one op per cycle throughput.
// Backpressure: Out_ready=0 holds S2 stable, S1 then stalls and In_ready drops; nothing is lost or duplicated.
module alu_arith_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Sel,
    input  logic             Carryin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Acc_sel,
    input  logic             Acc_clr,
    input  logic             In_valid,
    output logic             In_ready,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Result
`ifdef ALU_ARITH_PIPE_FLAGS_EN
    ,
    output logic [3:0]       Flags
`endif
);

    // S1: captured operands and opcode
    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_opc;
    logic             s1_acc_sel;

    // S2: result stage
    logic             s2_vld;
    logic [WIDTH-1:0] acc;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] aop;
    logic [WIDTH-1:0] x;
    logic             cin;

    // S1 moves forward when S2 is free or being drained this cycle
    assign advance   = s1_vld && (!s2_vld || Out_ready);
    assign In_ready  = !s1_vld || advance;
    assign accept    = In_valid && In_ready;
    assign Out_valid = s2_vld;

    // Accumulator is read at advance time so chained accumulate ops see the previous result
    assign aop = s1_acc_sel ? acc : s1_a;

    // Opcode {Sel,Carryin} selects the addend and carry-in
    always_comb begin
        x   = '0;
        cin = 1'b0;
        case (s1_opc)
            3'b000: begin x = '0;          cin = 1'b0; end
            3'b001: begin x = '0;          cin = 1'b1; end
            3'b010: begin x = s1_b;        cin = 1'b0; end
            3'b011: begin x = s1_b;        cin = 1'b1; end
            3'b100: begin x = ~s1_b;       cin = 1'b0; end
            3'b101: begin x = ~s1_b;       cin = 1'b1; end
            3'b110: begin x = '1;          cin = 1'b0; end
            default: begin x = '0;         cin = 1'b0; end
        endcase
    end

`ifdef ALU_ARITH_PIPE_FLAGS_EN
    logic [WIDTH:0] sum;
    logic [3:0]     flags_nxt;

    assign sum = {1'b0, aop} + {1'b0, x} + (WIDTH + 1)'(cin);

    // Overflow: both addends share a sign that differs from the result sign
    always_comb begin
        flags_nxt    = '0;
        flags_nxt[3] = sum[WIDTH];
        flags_nxt[2] = (aop[WIDTH-1] == x[WIDTH-1]) && (sum[WIDTH-1] != aop[WIDTH-1]);
        flags_nxt[1] = sum[WIDTH-1];
        flags_nxt[0] = (sum[WIDTH-1:0] == '0);
    end

    // Flag register tracks the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Flags <= '0;
        end else if (advance) begin
            Flags <= flags_nxt;
        end
    end
`else
    logic [WIDTH-1:0] sum;

    assign sum = aop + x + WIDTH'(cin);
`endif

    // S1 capture on handshake; valid drops once its op has moved on with nothing new behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_opc     <= '0;
            s1_acc_sel <= 1'b0;
        end else if (accept) begin
            s1_vld     <= 1'b1;
            s1_a       <= A;
            s1_b       <= B;
            s1_opc     <= {Sel, Carryin};
            s1_acc_sel <= Acc_sel;
        end else if (advance) begin
            s1_vld     <= 1'b0;
        end
    end

    // S2 loads on advance, empties when drained; holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            Result <= '0;
        end else if (advance) begin
            s2_vld <= 1'b1;
            Result <= sum[WIDTH-1:0];
        end else if (Out_ready) begin
            s2_vld <= 1'b0;
        end
    end

    // Accumulator follows each advancing result; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (Acc_clr) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_alu_arith_pipe.sv
// Directed bench for alu_arith_pipe at WIDTH=8; flag checks compile in with ALU_ARITH_PIPE_FLAGS_EN.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_alu_arith_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] Sel;
    logic       Carryin;
    logic [7:0] A;
    logic [7:0] B;
    logic       Acc_sel;
    logic       Acc_clr;
    logic       In_valid;
    logic       In_ready;
    logic       Out_valid;
    logic       Out_ready;
    logic [7:0] Result;
`ifdef ALU_ARITH_PIPE_FLAGS_EN
    logic [3:0] Flags;
`endif

    int vectors = 0;
    int miscompares = 0;

    alu_arith_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Sel       (Sel),
        .Carryin   (Carryin),
        .A         (A),
        .B         (B),
        .Acc_sel   (Acc_sel),
        .Acc_clr   (Acc_clr),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Result    (Result)
`ifdef ALU_ARITH_PIPE_FLAGS_EN
        ,
        .Flags     (Flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] exp);
`ifdef ALU_ARITH_PIPE_FLAGS_EN
        chk(tag, {28'd0, Flags}, {28'd0, exp});
`else
        if (exp === 4'bxxxx) $display("%s", tag);
`endif
    endtask

    // opcode is {Sel,Carryin}
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] opc, input logic asel);
        A        = a;
        B        = b;
        Sel      = opc[2:1];
        Carryin  = opc[0];
        Acc_sel  = asel;
        In_valid = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        A         = '0;
        B         = '0;
        Sel       = '0;
        Carryin   = 1'b0;
        Acc_sel   = 1'b0;
        Acc_clr   = 1'b0;
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        #3;
        // reset state
        chk("rst_out_valid", {31'd0, Out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, In_ready}, 32'd1);
        chk("rst_result", {24'd0, Result}, 32'h00);
        chk_flags("rst_flags", 4'b0000);

        // release between edges; first op accepted at the very next edge
        #9;
        rst_n = 1'b1;
        op(8'h7F, 8'h00, 3'b001, 1'b0);
        tick();
        In_valid = 1'b0;
        chk("lat_one_edge", {31'd0, Out_valid}, 32'd0);
        tick();
        chk("lat_two_edges", {31'd0, Out_valid}, 32'd1);
        chk("inc_7f", {24'd0, Result}, 32'h80);
        chk_flags("inc_7f_flags", 4'b0110);
        tick();
        chk("drained", {31'd0, Out_valid}, 32'd0);

        // subtract-equal and all-ones, back to back
        op(8'h05, 8'h05, 3'b101, 1'b0);
        tick();
        op(8'h00, 8'h00, 3'b110, 1'b0);
        tick();
        In_valid = 1'b0;
        chk("sub_eq", {24'd0, Result}, 32'h00);
        chk_flags("sub_eq_flags", 4'b1001);
        tick();
        chk("all_ones", {24'd0, Result}, 32'hFF);
        chk_flags("all_ones_flags", 4'b0010);
        tick();
        chk("drained2", {31'd0, Out_valid}, 32'd0);

        // clear accumulator, then chain three accumulate ops
        Acc_clr = 1'b1;
        tick();
        Acc_clr = 1'b0;
        op(8'h00, 8'h03, 3'b010, 1'b1);
        tick();
        tick();
        chk("acc_chain_1", {24'd0, Result}, 32'h03);
        tick();
        In_valid = 1'b0;
        chk("acc_chain_2", {24'd0, Result}, 32'h06);
        tick();
        chk("acc_chain_3", {24'd0, Result}, 32'h09);
        chk("acc_chain_vld", {31'd0, Out_valid}, 32'd1);
        tick();

        // backpressure: four ops offered with Out_ready low
        Out_ready = 1'b0;
        op(8'h10, 8'h01, 3'b010, 1'b0);
        #1;
        chk("bp_rdy0", {31'd0, In_ready}, 32'd1);
        tick();
        op(8'h11, 8'h01, 3'b010, 1'b0);
        chk("bp_rdy1", {31'd0, In_ready}, 32'd1);
        tick();
        op(8'h12, 8'h01, 3'b010, 1'b0);
        chk("bp_stall_rdy", {31'd0, In_ready}, 32'd0);
        chk("bp_vld", {31'd0, Out_valid}, 32'd1);
        chk("bp_res_a", {24'd0, Result}, 32'h11);
        tick();
        chk("bp_res_b", {24'd0, Result}, 32'h11);
        tick();
        chk("bp_res_c", {24'd0, Result}, 32'h11);
        chk("bp_stall_rdy2", {31'd0, In_ready}, 32'd0);
        Out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, In_ready}, 32'd1);
        tick();
        chk("bp_drain_1", {24'd0, Result}, 32'h12);
        op(8'h13, 8'h01, 3'b010, 1'b0);
        tick();
        In_valid = 1'b0;
        chk("bp_drain_2", {24'd0, Result}, 32'h13);
        tick();
        chk("bp_drain_3", {24'd0, Result}, 32'h14);
        chk("bp_drain_vld", {31'd0, Out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, Out_valid}, 32'd0);

        // clear coincides with an accumulate op advancing (acc holds 14)
        op(8'h00, 8'h02, 3'b010, 1'b1);
        tick();
        In_valid = 1'b0;
        Acc_clr  = 1'b1;
        tick();
        Acc_clr = 1'b0;
        chk("clr_adv_res", {24'd0, Result}, 32'h16);
        op(8'h00, 8'h01, 3'b010, 1'b1);
        tick();
        In_valid = 1'b0;
        tick();
        chk("clr_wins", {24'd0, Result}, 32'h01);
        tick();

        // reset with two ops in flight
        Out_ready = 1'b0;
        op(8'h33, 8'h01, 3'b010, 1'b0);
        tick();
        op(8'h44, 8'h01, 3'b010, 1'b0);
        tick();
        In_valid = 1'b0;
        chk("pre_rst_vld", {31'd0, Out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, Out_valid}, 32'd0);
        chk("mid_rst_res", {24'd0, Result}, 32'h00);
        chk("mid_rst_rdy", {31'd0, In_ready}, 32'd1);
        chk_flags("mid_rst_flags", 4'b0000);
        tick();
        #2;
        rst_n     = 1'b1;
        Out_ready = 1'b1;
        tick();
        chk("post_rst_1", {31'd0, Out_valid}, 32'd0);
        tick();
        chk("post_rst_2", {31'd0, Out_valid}, 32'd0);
        tick();
        chk("post_rst_3", {31'd0, Out_valid}, 32'd0);
        // accumulator must read zero after reset
        op(8'hAA, 8'h55, 3'b000, 1'b1);
        tick();
        In_valid = 1'b0;
        tick();
        chk("post_rst_acc", {24'd0, Result}, 32'h00);
        chk_flags("post_rst_acc_flags", 4'b0001);
        tick();

        // remaining opcodes streamed at full rate
        op(8'h5A, 8'h77, 3'b000, 1'b0);
        tick();
        op(8'h05, 8'h03, 3'b100, 1'b0);
        tick();
        chk("opc000", {24'd0, Result}, 32'h5A);
        chk_flags("opc000_flags", 4'b0000);
        op(8'h5A, 8'h77, 3'b111, 1'b0);
        tick();
        chk("opc100", {24'd0, Result}, 32'h01);
        chk_flags("opc100_flags", 4'b1000);
        op(8'hFF, 8'h00, 3'b011, 1'b0);
        tick();
        In_valid = 1'b0;
        chk("opc111", {24'd0, Result}, 32'h5A);
        chk_flags("opc111_flags", 4'b0000);
        tick();
        chk("opc011", {24'd0, Result}, 32'h00);
        chk_flags("opc011_flags", 4'b1001);
        tick();
        chk("final_empty", {31'd0, Out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
